vga_sync_tracker: RTL and testbench
===================================

Name: vga_sync_tracker

Overview:
- Receive-side counterpart of the VGA sync generator: consumes active-low vga_h_sync/vga_v_sync (same clock domain) and measures line length and lines per frame.
- Declares lock once timing is stable, then regenerates pixel coordinates and a display-area flag aligned to the generator's CounterX/CounterY.
- Sits in capture/overlay paths and in test benches that check generator timing.

Parameters:
- H_OFF, 46, clocks from first h_cnt==0 cycle to first active pixel.
- V_OFF, 12, v_cnt value of first active line.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- LOCK_LINES, 4, consecutive equal line lengths required for horizontal stability.

Ports:
- clk  input  1  system/pixel clock.
- reset  input  1  synchronous, active-high reset.
- vga_h_sync  input  1  horizontal sync, active low.
- vga_v_sync  input  1  vertical sync, active low.
- locked  output  1  timing stable; coordinates valid.
- line_len  output  10  last measured clocks per line.
- frame_lines  output  10  last measured lines per frame.
- pix_x  output  10  h_cnt - H_OFF, mod 1024.
- pix_y  output  9  v_cnt - V_OFF, low 9 bits.
- in_display  output  1  locked && H_OFF<=h_cnt<H_OFF+H_ACTIVE && V_OFF<=v_cnt<V_OFF+V_ACTIVE.
- sync_err  output  1  one-cycle pulse on lock loss.

Behaviour:
- Reset state: hs_prev=1, vs_prev=1, h_cnt=0, v_cnt=0, line_len=0, frame_lines=0, h_match=0, frame_valid=0, locked=0, sync_err=0.
- Edge detect: hs_prev<=vga_h_sync and vs_prev<=vga_v_sync each cycle. hs_fall = hs_prev & ~vga_h_sync; vs_fall is defined the same way. Detection latency is 0 cycles from the input sample.
- Horizontal counter:
  - On hs_fall: h_cnt<=0 and line_len<=h_cnt+1.
  - If h_cnt+1==line_len, h_match<=min(h_match+1, LOCK_LINES); otherwise h_match<=0.
  - Otherwise h_cnt<=h_cnt+1, saturating at 1023.
- Vertical counter:
  - v_cnt<=v_cnt+1 on hs_fall, saturating at 1023.
  - On vs_fall: v_cnt<=0 and frame_lines<=v_cnt.
  - frame_match is set on vs_fall when v_cnt==frame_lines and frame_valid==1.
  - frame_valid<=1 on the first vs_fall after reset.
  - Simultaneous hs_fall and vs_fall: vertical reset wins (v_cnt<=0); horizontal update proceeds normally.
- Lock acquisition: locked<=1 on a vs_fall where frame_match holds and h_match==LOCK_LINES. The earliest lock is the second vs_fall after reset.
- Lock loss: if locked==1, locked<=0 and sync_err pulses for 1 cycle on any of:
  - hs_fall with h_cnt+1!=line_len;
  - vs_fall with v_cnt!=frame_lines;
  - h_cnt reaching 1023 (lost HS).
  
  After loss, h_match<=0 and frame_valid stays 1, so relock needs one good frame plus LOCK_LINES good lines.
- Outputs pix_x, pix_y and in_display are combinational from registered h_cnt/v_cnt/locked. in_display is forced 0 while unlocked.
- Alignment with the standard generator (768-clock lines, 512-line frames, HS at X=721, VS at Y=500):
  - h_cnt = (CounterX-722) mod 768;
  - v_cnt = CounterY+12 for CounterX<722;
  - hence pix_x==CounterX and pix_y==CounterY throughout the active area.
- Reset mid-frame returns every register to its reset value on the next edge; lock reacquisition restarts from zero.

Test Plan:
- Drive from the standard generator (768x512) after reset -> line_len=768 after the second HS; frame_lines=512 at the first VS; locked rises at the second vs_fall; locked stays high for 3 more frames with sync_err never asserted.
- Once locked, compare against generator CounterX/CounterY every cycle -> pix_x/pix_y equal whenever in_display; in_display equals the generator's inDisplayArea delayed 1 cycle over 2 frames.
- Stretch one line to 770 clocks while locked -> sync_err pulses once at that hs_fall; locked=0; relock at the next vs_fall that follows ≥4 good lines and a 512-line frame.
- Hold vga_h_sync high while locked -> h_cnt saturates at 1023; sync_err pulses once; locked=0; in_display=0.
- Assert reset mid-line while locked -> next cycle locked=0, line_len=0, frame_lines=0, pix_x=(0-46) mod 1024=978.
- VS edge in the same cycle as HS edge -> v_cnt=0 next cycle and line_len is still updated correctly.

Source files
------------

// File: rtl/vga_sync_tracker.sv
// Receive-side VGA timing tracker: measures line and frame length from active-low
// syncs, declares lock once both are stable, and regenerates pixel coordinates.
module vga_sync_tracker #(
    parameter int H_OFF      = 46,
    parameter int V_OFF      = 12,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vga_h_sync,
    input  logic       vga_v_sync,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       in_display,
    output logic       sync_err
);

    localparam int               HM_W     = $clog2(LOCK_LINES + 1);
    localparam logic [HM_W-1:0]  LOCK_CNT = HM_W'(LOCK_LINES);
    localparam logic [9:0]       CNT_MAX  = 10'd1023;
    localparam logic [9:0]       H_OFF_W  = 10'(H_OFF);
    localparam logic [8:0]       V_OFF_W  = 9'(V_OFF);
    localparam logic [10:0]      H_START  = 11'(H_OFF);
    localparam logic [10:0]      H_END    = 11'(H_OFF + H_ACTIVE);
    localparam logic [10:0]      V_START  = 11'(V_OFF);
    localparam logic [10:0]      V_END    = 11'(V_OFF + V_ACTIVE);

    logic            r_hs_prev;
    logic            r_vs_prev;
    logic [9:0]      r_h_cnt;
    logic [9:0]      r_v_cnt;
    logic [9:0]      r_line_len;
    logic [9:0]      r_frame_lines;
    logic [HM_W-1:0] r_h_match;
    logic            r_frame_valid;
    logic            r_locked;
    logic            r_sync_err;

    logic            w_hs_fall;
    logic            w_vs_fall;
    logic [10:0]     w_h_len;
    logic            w_line_ok;
    logic            w_h_err;
    logic            w_v_err;
    logic            w_hs_lost;
    logic            w_frame_match;
    logic            w_lose;
    logic            w_acquire;

    // Edges are taken against the live input so a sync edge acts in the cycle it arrives.
    assign w_hs_fall     = r_hs_prev & ~vga_h_sync;
    assign w_vs_fall     = r_vs_prev & ~vga_v_sync;

    // Line length is compared at 11 bits so a saturated counter never aliases a valid length.
    assign w_h_len       = {1'b0, r_h_cnt} + 11'd1;
    assign w_line_ok     = (w_h_len == {1'b0, r_line_len});
    assign w_h_err       = w_hs_fall & ~w_line_ok;
    assign w_v_err       = w_vs_fall & (r_v_cnt != r_frame_lines);
    assign w_hs_lost     = (r_h_cnt == CNT_MAX);
    assign w_frame_match = w_vs_fall & r_frame_valid & (r_v_cnt == r_frame_lines);
    assign w_lose        = r_locked & (w_h_err | w_v_err | w_hs_lost);
    assign w_acquire     = ~r_locked & w_frame_match & (r_h_match == LOCK_CNT)
                         & ~w_h_err & ~w_hs_lost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_prev     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_h_match     <= '0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every test below sees pre-edge state.
            r_hs_prev  <= vga_h_sync;
            r_vs_prev  <= vga_v_sync;
            r_sync_err <= w_lose;

            if (w_hs_fall) begin
                r_h_cnt    <= '0;
                r_line_len <= w_h_len[9:0];
                if (w_line_ok)
                    r_h_match <= (r_h_match == LOCK_CNT) ? LOCK_CNT : r_h_match + 1'b1;
                else
                    r_h_match <= '0;
            end else if (r_h_cnt != CNT_MAX) begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end

            // Frame start takes priority over the line increment on a shared edge.
            if (w_vs_fall) begin
                r_v_cnt       <= '0;
                r_frame_lines <= r_v_cnt;
                r_frame_valid <= 1'b1;
            end else if (w_hs_fall && (r_v_cnt != CNT_MAX)) begin
                r_v_cnt <= r_v_cnt + 10'd1;
            end

            if (w_lose) begin
                r_locked  <= 1'b0;
                r_h_match <= '0;
            end else if (w_acquire) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign locked      = r_locked;
    assign sync_err    = r_sync_err;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign pix_x       = r_h_cnt - H_OFF_W;
    assign pix_y       = r_v_cnt[8:0] - V_OFF_W;
    assign in_display  = r_locked
                       && ({1'b0, r_h_cnt} >= H_START) && ({1'b0, r_h_cnt} < H_END)
                       && ({1'b0, r_v_cnt} >= V_START) && ({1'b0, r_v_cnt} < V_END);

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Bench for vga_sync_tracker driven by a scaled-down generator model
// (100-clock lines, 40-line frames) so several frames fit in a short run.
module tb_vga_sync_tracker;

    localparam int L        = 100;
    localparam int F        = 40;
    localparam int HS_X     = 80;
    localparam int VS_Y     = 34;
    localparam int H_OFF    = 18;
    localparam int V_OFF    = 6;
    localparam int H_ACTIVE = 64;
    localparam int V_ACTIVE = 30;
    localparam int BUDGET   = 6000;
    localparam logic [9:0] RST_PIX_X = 10'(1024 - H_OFF);
    localparam logic [8:0] RST_PIX_Y = 9'(512 - V_OFF);

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic       locked;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       in_display;
    logic       sync_err;

    vga_sync_tracker #(
        .H_OFF(H_OFF), .V_OFF(V_OFF), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .LOCK_LINES(4)
    ) dut (
        .clk(clk), .reset(reset), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .locked(locked), .line_len(line_len), .frame_lines(frame_lines),
        .pix_x(pix_x), .pix_y(pix_y), .in_display(in_display), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lck;
        logic       err;
        logic       disp;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass   = 0;
    int   n_checks = 0;

    // Generator model: counters, registered syncs, one optionally stretched line.
    logic [9:0] gx = '0;
    logic [9:0] gy = '0;
    logic       g_hs = 1'b0;
    logic       g_vs = 1'b0;
    int         cur_max = L - 1;
    int         long_line_y = -1;
    int         vs_x = 0;
    logic       hold_hs = 1'b0;
    logic       sb_on = 1'b0;

    assign vga_h_sync = ~(g_hs & ~hold_hs);
    assign vga_v_sync = ~g_vs;

    always @(posedge clk) begin : gen
        int   nx;
        int   ny;
        exp_t e;
        if (int'(gx) >= cur_max) begin
            nx = 0;
            ny = (int'(gy) == F - 1) ? 0 : int'(gy) + 1;
            cur_max <= (ny == long_line_y) ? L + 1 : L - 1;
        end else begin
            nx = int'(gx) + 1;
            ny = int'(gy);
        end
        gx   <= 10'(nx);
        gy   <= 10'(ny);
        g_hs <= (int'(gx) >= HS_X) && (int'(gx) < HS_X + 16);
        g_vs <= (int'(gy) == VS_Y) && (int'(gx) >= vs_x) && (int'(gx) < vs_x + 16);
        if (sb_on) begin
            e.lck  = 1'b1;
            e.err  = 1'b0;
            e.disp = (nx < H_ACTIVE) && (ny < V_ACTIVE);
            e.x    = 10'(nx);
            e.y    = 9'(ny);
            sb_q.push_back(e);
        end
    end

    task automatic wait_pos(input int y, input int x);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((int'(gy) == y) && (int'(gx) == x)) && (n < BUDGET));
        if (n >= BUDGET) begin
            n_checks++;
            $display("FAIL wait_pos: position (%0d,%0d) not reached in %0d cycles", y, x, BUDGET);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (locked !== 1'b0) $display("FAIL rst_locked: got %b want 0", locked); else n_pass++;
        if (sync_err !== 1'b0) $display("FAIL rst_sync_err: got %b want 0", sync_err); else n_pass++;
        if (line_len !== 10'd0) $display("FAIL rst_line_len: got %0d want 0", line_len); else n_pass++;
        if (frame_lines !== 10'd0) $display("FAIL rst_frame_lines: got %0d want 0", frame_lines); else n_pass++;
        if (in_display !== 1'b0) $display("FAIL rst_in_display: got %b want 0", in_display); else n_pass++;
        if (pix_x !== RST_PIX_X) $display("FAIL rst_pix_x: got %0d want %0d", pix_x, RST_PIX_X); else n_pass++;
        if (pix_y !== RST_PIX_Y) $display("FAIL rst_pix_y: got %0d want %0d", pix_y, RST_PIX_Y); else n_pass++;
    endtask

    task automatic test_acquire();
        wait_pos(VS_Y, 40);
        reset = 1'b0;
        wait_pos(VS_Y, HS_X + 2);
        n_checks++;
        if (line_len !== 10'd42) $display("FAIL acq_first_hs_len: got %0d want 42", line_len); else n_pass++;
        wait_pos(VS_Y + 1, HS_X + 2);
        n_checks++;
        if (line_len !== 10'(L)) $display("FAIL acq_line_len: got %0d want %0d", line_len, L); else n_pass++;
        wait_pos(VS_Y, 2);
        n_checks += 2;
        if (frame_lines !== 10'(F)) $display("FAIL acq_frame_lines: got %0d want %0d", frame_lines, F); else n_pass++;
        if (locked !== 1'b0) $display("FAIL acq_early_lock_vs1: got %b want 0", locked); else n_pass++;
        wait_pos(VS_Y - 1, 50);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL acq_early_lock: got %b want 0", locked); else n_pass++;
        wait_pos(VS_Y, 2);
        n_checks += 2;
        if (locked !== 1'b1) $display("FAIL acq_lock_vs2: got %b want 1", locked); else n_pass++;
        if (sync_err !== 1'b0) $display("FAIL acq_sync_err: got %b want 0", sync_err); else n_pass++;
    endtask

    task automatic test_tracking(input int cycles);
        exp_t e;
        sb_q.delete();
        sb_on = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL track_queue: empty at cycle %0d", i);
            end else begin
                e = sb_q.pop_front();
                if (locked !== e.lck || sync_err !== e.err || in_display !== e.disp
                    || (e.disp && (pix_x !== e.x || pix_y !== e.y)))
                    $display("FAIL track: got lck=%b err=%b disp=%b x=%0d y=%0d want lck=%b err=%b disp=%b x=%0d y=%0d",
                             locked, sync_err, in_display, pix_x, pix_y, e.lck, e.err, e.disp, e.x, e.y);
                else
                    n_pass++;
            end
        end
        sb_on = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_stretch();
        wait_pos(5, 0);
        long_line_y = 10;
        wait_pos(11, HS_X + 1);
        long_line_y = -1;
        n_checks += 2;
        if (locked !== 1'b1) $display("FAIL str_pre_locked: got %b want 1", locked); else n_pass++;
        if (sync_err !== 1'b0) $display("FAIL str_pre_err: got %b want 0", sync_err); else n_pass++;
        @(negedge clk);
        n_checks += 3;
        if (sync_err !== 1'b1) $display("FAIL str_err_pulse: got %b want 1", sync_err); else n_pass++;
        if (locked !== 1'b0) $display("FAIL str_unlock: got %b want 0", locked); else n_pass++;
        if (line_len !== 10'(L + 2)) $display("FAIL str_line_len: got %0d want %0d", line_len, L + 2); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (sync_err !== 1'b0) $display("FAIL str_err_width: got %b want 0", sync_err); else n_pass++;
        wait_pos(VS_Y - 1, 50);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL str_early_relock: got %b want 0", locked); else n_pass++;
        wait_pos(VS_Y, 2);
        n_checks += 2;
        if (locked !== 1'b1) $display("FAIL str_relock: got %b want 1", locked); else n_pass++;
        if (frame_lines !== 10'(F)) $display("FAIL str_frame_lines: got %0d want %0d", frame_lines, F); else n_pass++;
    endtask

    task automatic test_reset_midline();
        wait_pos(10, 30);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL rml_pre_locked: got %b want 1", locked); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (locked !== 1'b0) $display("FAIL rml_locked: got %b want 0", locked); else n_pass++;
        if (line_len !== 10'd0) $display("FAIL rml_line_len: got %0d want 0", line_len); else n_pass++;
        if (frame_lines !== 10'd0) $display("FAIL rml_frame_lines: got %0d want 0", frame_lines); else n_pass++;
        if (pix_x !== RST_PIX_X) $display("FAIL rml_pix_x: got %0d want %0d", pix_x, RST_PIX_X); else n_pass++;
        if (in_display !== 1'b0) $display("FAIL rml_in_display: got %b want 0", in_display); else n_pass++;
    endtask

    task automatic test_coincident();
        vs_x = HS_X;
        wait_pos(VS_Y - 1, 40);
        reset = 1'b0;
        wait_pos(VS_Y, HS_X + 2);
        n_checks += 4;
        if (line_len !== 10'(L)) $display("FAIL coin_line_len: got %0d want %0d", line_len, L); else n_pass++;
        if (frame_lines !== 10'd1) $display("FAIL coin_frame_lines: got %0d want 1", frame_lines); else n_pass++;
        if (pix_y !== RST_PIX_Y) $display("FAIL coin_v_cnt_zero: got pix_y %0d want %0d", pix_y, RST_PIX_Y); else n_pass++;
        if (locked !== 1'b0) $display("FAIL coin_locked0: got %b want 0", locked); else n_pass++;
        wait_pos(VS_Y, HS_X + 2);
        n_checks += 2;
        if (frame_lines !== 10'(F - 1)) $display("FAIL coin_frame2: got %0d want %0d", frame_lines, F - 1); else n_pass++;
        if (locked !== 1'b0) $display("FAIL coin_locked1: got %b want 0", locked); else n_pass++;
        wait_pos(VS_Y, HS_X + 2);
        n_checks += 2;
        if (frame_lines !== 10'(F - 1)) $display("FAIL coin_frame3: got %0d want %0d", frame_lines, F - 1); else n_pass++;
        if (locked !== 1'b1) $display("FAIL coin_relock: got %b want 1", locked); else n_pass++;
    endtask

    task automatic test_hold_hs();
        int bad;
        wait_pos(5, 10);
        hold_hs = 1'b1;
        // Last HS edge at (4,81): the counter hits 1023 at (15,5), error shows at (15,6).
        wait_pos(15, 5);
        n_checks += 2;
        if (locked !== 1'b1) $display("FAIL hold_pre_locked: got %b want 1", locked); else n_pass++;
        if (sync_err !== 1'b0) $display("FAIL hold_pre_err: got %b want 0", sync_err); else n_pass++;
        @(negedge clk);
        n_checks += 3;
        if (sync_err !== 1'b1) $display("FAIL hold_err_pulse: got %b want 1", sync_err); else n_pass++;
        if (locked !== 1'b0) $display("FAIL hold_unlock: got %b want 0", locked); else n_pass++;
        if (in_display !== 1'b0) $display("FAIL hold_in_display: got %b want 0", in_display); else n_pass++;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sync_err !== 1'b0 || locked !== 1'b0 || in_display !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL hold_after: got %0d bad cycles want 0", bad); else n_pass++;
        hold_hs = 1'b0;
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_tracking(3 * F * L);
        test_stretch();
        test_reset_midline();
        test_coincident();
        test_hold_hs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
